// File: rtl/dpram_fifo_ctrl.sv
// Sequencer that wraps a 16x8 dual-port RAM as a synchronous FIFO:
// pointers, occupancy, flags, one-cycle pop-valid timing and sticky error flags.
module dpram_fifo_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_acc, pop_acc;

  // Flags come from the registered count only, so a same-cycle pop never
  // frees room for a push and a same-cycle push never feeds a pop.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  assign push_acc = push & ~full & ~flush;
  assign pop_acc  = pop & ~empty & ~flush;

  assign ram_wr_en   = push_acc;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_data_in = push_data;
  assign ram_rd_en   = pop_acc;
  assign ram_rd_addr = rd_ptr_q;

  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_data_out;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pop_valid_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // Pointers roll over naturally at ADDR_W bits.
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      if (push && full)  overflow_d  = 1'b1;
      if (pop  && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 16x8 registered-read RAM.
module tb_dpram_fifo_ctrl;

  logic       clk, reset_n, flush, push, pop;
  logic [7:0] push_data, pop_data, ram_data_in, ram_data_out;
  logic       pop_valid, full, empty, overflow, underflow, ram_wr_en, ram_rd_en;
  logic [4:0] count;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  dpram_fifo_ctrl #(.ADDR_W(4), .DEPTH(16), .DATA_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_valid    (pop_valid),
    .pop_data     (pop_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    #1 reset_n = 1'b0;
    #10;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    #2 reset_n = 1'b1;
    tick();

    // Three pushes then three pops
    push = 1'b1; push_data = 8'h11; #1;
    chk("p1_wr_en", ram_wr_en, 1);
    chk("p1_wr_addr", ram_wr_addr, 0);
    chk("p1_data_in", ram_data_in, 8'h11);
    tick(); chk("p1_count", count, 1);
    push_data = 8'h22; tick(); chk("p2_count", count, 2);
    push_data = 8'h33; tick(); chk("p3_count", count, 3);
    push = 1'b0; pop = 1'b1; #1;
    chk("q1_rd_en", ram_rd_en, 1);
    chk("q1_rd_addr", ram_rd_addr, 0);
    tick(); chk("q1_count", count, 2); chk("q1_valid", pop_valid, 1); chk("q1_data", pop_data, 8'h11);
    tick(); chk("q2_count", count, 1); chk("q2_valid", pop_valid, 1); chk("q2_data", pop_data, 8'h22);
    tick(); chk("q3_count", count, 0); chk("q3_valid", pop_valid, 1); chk("q3_data", pop_data, 8'h33);
    pop = 1'b0;
    tick(); chk("q_end_valid", pop_valid, 0); chk("q_end_empty", empty, 1);
    chk("q_end_underflow", underflow, 0);

    // Fill to 16, then refused 17th push
    push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_data = 8'(i);
      tick();
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    push_data = 8'hEE; #1;
    chk("ovf_wr_en", ram_wr_en, 0);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);

    // Push and pop while full: pop wins, push refused
    pop = 1'b1; #1;
    chk("fp_wr_en", ram_wr_en, 0);
    chk("fp_rd_en", ram_rd_en, 1);
    tick();
    chk("fp_count", count, 15);
    chk("fp_overflow", overflow, 1);
    chk("fp_data", pop_data, 8'h00);
    push = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("drain_valid", pop_valid, 1);
      chk("drain_data", pop_data, 32'(i));
    end
    chk("drain_empty", empty, 1);
    #1 chk("udf_rd_en", ram_rd_en, 0);
    tick();
    chk("udf_valid", pop_valid, 0);
    chk("udf_flag", underflow, 1);

    // Push and pop while empty: push wins, pop refused
    push = 1'b1; push_data = 8'h55; #1;
    chk("ep_wr_en", ram_wr_en, 1);
    chk("ep_rd_en", ram_rd_en, 0);
    tick();
    chk("ep_count", count, 1);
    chk("ep_valid", pop_valid, 0);

    // Flush clears everything including sticky errors
    push = 1'b0; pop = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    chk("fl1_count", count, 0);
    chk("fl1_empty", empty, 1);
    chk("fl1_overflow", overflow, 0);
    chk("fl1_underflow", underflow, 0);

    // Wrap: fill 10, drain 10, then 10 more across the 15->0 boundary
    push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_data = 8'(8'h30 + i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("w1_data", pop_data, 32'(8'h30 + i));
    end
    pop = 1'b0; push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_data = 8'(8'hA0 + i); #1;
      chk("w2_wr_addr", ram_wr_addr, 32'((10 + i) % 16));
      tick();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("w2_rd_addr", ram_rd_addr, 32'((10 + i) % 16));
      tick();
      chk("w2_valid", pop_valid, 1);
      chk("w2_data", pop_data, 32'(8'hA0 + i));
    end
    pop = 1'b0;
    tick(); chk("w2_empty", empty, 1);

    // Count 5, accept a pop, flush the next cycle with requests held
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = 8'(8'h60 + i);
      tick();
    end
    chk("f5_count", count, 5);
    push = 1'b0; pop = 1'b1;
    tick();
    chk("f5_pop_count", count, 4);
    push = 1'b1; flush = 1'b1; #1;
    chk("fl2_wr_en", ram_wr_en, 0);
    chk("fl2_rd_en", ram_rd_en, 0);
    tick();
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    chk("fl2_count", count, 0);
    chk("fl2_empty", empty, 1);
    chk("fl2_valid", pop_valid, 0);
    chk("fl2_overflow", overflow, 0);
    chk("fl2_underflow", underflow, 0);

    // Async reset mid-burst with a pop in flight
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data = 8'(8'h70 + i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_valid", pop_valid, 0);
    chk("ar_rd_en", ram_rd_en, 0);
    tick();
    chk("ar_valid_held", pop_valid, 0);
    pop = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("ar_after_valid", pop_valid, 0);
    chk("ar_after_count", count, 0);
    push = 1'b1; push_data = 8'h99; #1;
    chk("ar_wr_addr", ram_wr_addr, 0);
    tick();
    push = 1'b0;
    chk("ar_push_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Sequencer that drives the 16x8 dual-port RAM's write and read ports so the RAM behaves as a synchronous FIFO.
- Owns the write/read pointers, occupancy count, full/empty flags, pop-valid timing and the error flags.
- Sits between producer/consumer logic and the RAM; the RAM itself stays unchanged.

Parameters:
- ADDR_W, 4, RAM address width.
- DEPTH, 16, number of entries; must equal 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of the FIFO state.
- push  input  1  producer write request.
- push_data  input  DATA_W  producer data.
- pop  input  1  consumer read request.
- pop_valid  output  1  pop_data is valid this cycle.
- pop_data  output  DATA_W  read data; pass-through of ram_data_out.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: a push was refused.
- underflow  output  1  sticky: a pop was refused.
- ram_wr_en  output  1  to the RAM write enable.
- ram_wr_addr  output  ADDR_W  to the RAM write address.
- ram_data_in  output  DATA_W  to the RAM data input; equals push_data.
- ram_rd_en  output  1  to the RAM read enable.
- ram_rd_addr  output  ADDR_W  to the RAM read address.
- ram_data_out  input  DATA_W  from the RAM registered read data.

Behaviour:
- Reset (reset_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0.
  - pop_data mirrors ram_data_out and is don't-care while pop_valid=0.
  - The RAM contents are not cleared; stale data is never exposed because empty=1.
  - Reset mid-operation drops every in-flight pop, including a pop_valid that would have asserted next cycle.
- Accepted push: push_acc = push & !full & !flush.
  - ram_wr_en = push_acc (combinational).
  - ram_wr_addr = wr_ptr.
  - wr_ptr increments on clk when push_acc=1.
- Accepted pop: pop_acc = pop & !empty & !flush.
  - ram_rd_en = pop_acc (combinational).
  - ram_rd_addr = rd_ptr.
  - rd_ptr increments on clk when pop_acc=1.
- Read latency is 1 cycle: pop_valid is pop_acc registered, and pop_data=ram_data_out in the cycle pop_valid=1.
- Pointers wrap modulo DEPTH (natural ADDR_W-bit rollover, 15 -> 0).
- Count update per cycle:
  - +1 when push_acc only.
  - -1 when pop_acc only.
  - Unchanged when both or neither.
  - full and empty are decoded from the registered count.
- Full and empty are evaluated on the registered count, never on same-cycle requests:
  - Push while full is refused even if a pop is accepted in the same cycle.
  - Pop while empty is refused even if a push is accepted in the same cycle.
  - This also removes read/write collisions on the same address: a just-written entry is never read in the same edge.
- Errors:
  - overflow sets on push & full & !flush.
  - underflow sets on pop & empty & !flush.
  - Both are sticky until flush or reset.
- Flush (synchronous, highest priority after reset): next edge sets pointers=0, count=0, pop_valid=0, overflow=0, underflow=0.
  - ram_wr_en and ram_rd_en are 0 during a flush cycle.
- Steady-state throughput is one push and one pop per cycle.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on 3 consecutive cycles, then pop 3 cycles -> pop_valid pulses one cycle after each pop with 0x11,0x22,0x33 in order; count sequence 1,2,3,2,1,0; empty=1 at end.
- Push 16 values 0x00..0x0F -> full=1 and count=16; 17th push -> ram_wr_en=0, overflow=1, count stays 16.
- With count=16, assert push and pop together -> pop accepted, push refused; count=15 and overflow=1.
- Pop on empty FIFO -> ram_rd_en=0, pop_valid stays 0, underflow=1; next push plus pop -> push accepted, pop refused, count=1.
- Fill 10, drain 10, then push 10 more -> pointers wrap 15->0; data read back in order, e.g. 0xA0..0xA9.
- With count=5 and a pop accepted, assert flush next cycle -> count=0, empty=1, overflow/underflow=0.
  - Async reset_n low mid-burst clears all state within the same cycle, with no pop_valid afterwards.
